// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline types for the fetch stage: NOP encoding, fetch FSM states
// and the IF/ID pipeline register layout.
package if_fetch_stage_pkg;

    localparam int          FETCH_PC_W    = 9;
    localparam int          FETCH_INSTR_W = 32;
    localparam logic [31:0] FETCH_NOP     = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    Curr_Pc;
        logic [FETCH_INSTR_W-1:0] Curr_Instr;
    } if_id_reg;

endpackage

// File: rtl/if_fetch_stage_perf_ctr.sv
// fetch_perf_ctr: 32-bit saturating event counter, cleared by synchronous reset.
module fetch_perf_ctr (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID register, redirect/halt/stall handling.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
//
//   state        | meaning
//   FETCH_RUN    | fetching; redirect > halt > stall > advance
//   FETCH_HALTED | fetch stopped, IF/ID holds a bubble until reset
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output if_id_reg           if_id,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_count
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    if_id_reg        r_if_id;
    if_id_reg        w_if_id_nxt;
    logic            r_valid;
    logic            w_valid_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= FETCH_RUN;
            r_pc               <= RESET_PC;
            r_if_id.Curr_Pc    <= RESET_PC;
            r_if_id.Curr_Instr <= FETCH_NOP;
            r_valid            <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_if_id <= w_if_id_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_if_id_nxt = r_if_id;
        w_valid_nxt = r_valid;
        if (r_state == FETCH_RUN) begin
            // A redirect squashes any halt or stall: both belong to the wrong path.
            if (redirect_valid) begin
                w_pc_nxt               = {redirect_pc[PC_W-1:2], 2'b00};
                w_if_id_nxt.Curr_Pc    = r_pc;
                w_if_id_nxt.Curr_Instr = FETCH_NOP;
                w_valid_nxt            = 1'b0;
            end else if (halt_req) begin
                w_state_nxt            = FETCH_HALTED;
                w_if_id_nxt.Curr_Pc    = r_pc;
                w_if_id_nxt.Curr_Instr = FETCH_NOP;
                w_valid_nxt            = 1'b0;
            end else if (!stall) begin
                w_pc_nxt               = r_pc + PC_W'(4);
                w_if_id_nxt.Curr_Pc    = r_pc;
                w_if_id_nxt.Curr_Instr = imem_rdata;
                w_valid_nxt            = 1'b1;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign if_id       = r_if_id;
    assign if_id_valid = r_valid;
    assign halted      = (r_state == FETCH_HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic w_stall_take;
    logic w_redir_take;

    assign w_redir_take = (r_state == FETCH_RUN) && redirect_valid;
    assign w_stall_take = (r_state == FETCH_RUN) && !redirect_valid && !halt_req && stall;

    fetch_perf_ctr u_stall_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_take),
        .count (stall_cycles)
    );

    fetch_perf_ctr u_flush_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_redir_take),
        .count (flush_count)
    );
`else
    assign stall_cycles = 32'h0;
    assign flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a rule-level fetch model predicts every
// post-edge state; a negedge monitor compares the DUT against those predictions.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [8:0]  redirect_pc = 9'h000;
    logic        halt_req = 1'b0;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    if_id_reg    if_id;
    logic        if_id_valid;
    logic [8:0]  pc;
    logic        halted;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'h1000_0000 | {23'd0, imem_addr};

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id          (if_id),
        .if_id_valid    (if_id_valid),
        .pc             (pc),
        .halted         (halted),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    typedef struct {
        int unsigned pc;
        int unsigned id_pc;
        int unsigned id_instr;
        bit          id_pc_known;
        bit          valid;
        bit          halted;
        int unsigned stalls;
        int unsigned flushes;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state, in plain integers.
    int unsigned m_pc, m_id_pc, m_id_instr, m_stalls, m_flushes;
    bit          m_valid, m_halted, m_id_pc_known;

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            m_pc = 0; m_id_pc = 0; m_id_instr = 32'h13; m_id_pc_known = 1;
            m_valid = 0; m_halted = 0; m_stalls = 0; m_flushes = 0;
        end else if (!m_halted) begin
            if (redirect_valid) begin
                m_id_pc = m_pc; m_id_pc_known = 1; m_id_instr = 32'h13; m_valid = 0;
                m_pc = (redirect_pc / 4) * 4;
                m_flushes = sat_inc(m_flushes);
            end else if (halt_req) begin
                m_id_instr = 32'h13; m_valid = 0; m_id_pc_known = 0; m_halted = 1;
            end else if (stall) begin
                m_stalls = sat_inc(m_stalls);
            end else begin
                m_id_pc = m_pc; m_id_pc_known = 1; m_id_instr = 32'h1000_0000 + m_pc; m_valid = 1;
                m_pc = (m_pc + 4) % 512;
            end
        end
        e.pc = m_pc; e.id_pc = m_id_pc; e.id_instr = m_id_instr; e.id_pc_known = m_id_pc_known;
        e.valid = m_valid; e.halted = m_halted;
`ifdef FETCH_PERF_CNT_EN
        e.stalls = m_stalls; e.flushes = m_flushes;
`else
        e.stalls = 0; e.flushes = 0;
`endif
        exp_q.push_back(e);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",           {23'd0, pc},          e.pc);
            chk("imem_addr",    {23'd0, imem_addr},   e.pc);
            chk("if_id_valid",  {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("curr_instr",   if_id.Curr_Instr,     e.id_instr);
            chk("halted",       {31'd0, halted},      {31'd0, e.halted});
            chk("stall_cycles", stall_cycles,         e.stalls);
            chk("flush_count",  flush_count,          e.flushes);
            if (e.id_pc_known)
                chk("curr_pc",  {23'd0, if_id.Curr_Pc}, e.id_pc);
        end
    end

    task automatic cyc(input bit rst, input bit st, input bit rv, input logic [8:0] rpc, input bit hr);
        reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc; halt_req = hr;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // reset then free-run
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        // stall three cycles at pc=0x008
        cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        // redirect with stall, unaligned target
        cyc(0, 1, 1, 9'h0A3, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        // halt, then ignored inputs, then reset
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 9'h040, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // halt and redirect together
        cyc(0, 0, 1, 9'h120, 1);
        repeat (2) cyc(0, 0, 0, 0, 0);
        // wrap at the top of the address space
        cyc(0, 0, 1, 9'h1FC, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 10,
                9'($urandom_range(0, 511)),
                $urandom_range(0, 99) < 3);
        end
        cyc(0, 0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage of the 5-stage RV32 pipeline. Holds the program counter, drives the instruction memory address, and loads the IF/ID pipeline register (`if_id_reg`: `Curr_Pc`, `Curr_Instr`) each cycle. It honours stall requests from the hazard unit, PC redirects from EX (taken branch / JAL / JALR), and the halt instruction decoded in ID. It sits directly upstream of decode.

## Interface
- `PC_W`, 9: PC width, byte address; must equal the `Curr_Pc` width.
- `INSTR_W`, 32: instruction width.
- `RESET_PC`, 9'h000: PC value after reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit load-use stall; hold PC and IF/ID.
- `redirect_valid`  in  1  EX resolved a taken branch or jump.
- `redirect_pc`  in  PC_W  redirect target; bits [1:0] are ignored and forced to 0.
- `halt_req`  in  1  ID holds a halt instruction (`haltPut`).
- `imem_addr`  out  PC_W  combinational, equal to `pc`.
- `imem_rdata`  in  INSTR_W  combinational instruction memory read data for `imem_addr`.
- `if_id`  out  if_id_reg  registered IF/ID contents.
- `if_id_valid`  out  1  1 when `if_id` holds a real fetched instruction; 0 for a bubble.
- `pc`  out  PC_W  current fetch PC.
- `halted`  out  1  fetch has stopped permanently until reset.
- `stall_cycles`  out  32  count of stalled cycles (see Configuration).
- `flush_count`  out  32  count of redirects taken (see Configuration).

## Operation
- FSM states: RUN and HALTED. RUN→HALTED when `halt_req` is 1 and `redirect_valid` is 0. HALTED exits only on `reset`.
- Per-edge priority in RUN is reset > redirect > halt > stall > advance:
  - reset: `pc`=RESET_PC, `if_id`={RESET_PC, NOP}, `if_id_valid`=0, state RUN, counters 0.
  - redirect: `pc`←{redirect_pc[8:2],2'b00}; `if_id`←{current pc, NOP}; `if_id_valid`←0. This flushes the wrong-path instruction. A simultaneous `halt_req` or `stall` is ignored because the halt or stalled instruction is on the wrong path.
  - halt: `pc` holds; `if_id`←bubble (NOP, valid 0); state←HALTED.
  - stall: `pc`, `if_id` and `if_id_valid` all hold.
  - advance: `if_id`←{pc, imem_rdata}; `if_id_valid`←1; `pc`←pc+4.
- In HALTED: `pc` is frozen, `if_id` holds a bubble, and `stall`, `redirect_valid` and `halt_req` are ignored. `halted`=1.
- NOP is 32'h0000_0013 (addi x0,x0,0).
- PC arithmetic is modulo 2^PC_W: 9'h1FC+4 wraps to 9'h000 with no error.
- Reset values: `pc`=RESET_PC, `imem_addr`=RESET_PC, `if_id.Curr_Pc`=RESET_PC, `if_id.Curr_Instr`=NOP, `if_id_valid`=0, `halted`=0, `stall_cycles`=0, `flush_count`=0.

## Timing
- Fetch latency is 1 cycle: the instruction at `pc` in cycle N appears on `if_id` after edge N.
- Redirect latency: the target instruction appears on `if_id` 2 edges after `redirect_valid`. Exactly one bubble is inserted.
- A stall asserted for k cycles freezes `if_id` for exactly k edges. There is no skid and no lost instruction.
- `halted` rises on the edge that consumes `halt_req`.
- Reset asserted mid-operation, including in HALTED, takes effect on the next edge and overrides every other input.

## Configuration
- `FETCH_PERF_CNT_EN` defined: `stall_cycles` increments on each RUN edge taken by the stall branch. `flush_count` increments on each redirect edge. Both saturate at 32'hFFFF_FFFF and clear on reset.
- `FETCH_PERF_CNT_EN` not defined: no counter flops are built, and both ports are tied to 32'h0.

## Structure
- Shared pipeline package gets `FETCH_NOP` (32'h0000_0013), the `fetch_state_e` enum {FETCH_RUN, FETCH_HALTED}, and the `if_id_reg` type, which is reused unchanged.
- One sub-module, `fetch_perf_ctr`: a saturating 32-bit counter with `clk`, `reset` and `inc`. It is instantiated twice, and only under `FETCH_PERF_CNT_EN`.

## Test plan
- Reset then 4 free-running cycles with imem returning 32'h1000_0000|addr. Expected: `if_id` PCs 0,4,8,C in order; `if_id_valid`=1 from the 1st edge; `pc`=0x010.
- `stall` held 3 cycles at pc=0x008. Expected: `if_id` stays {0x004, instr}, `pc` stays 0x008; with the macro defined, `stall_cycles`=3. Fetch resumes at 0x008 with no skipped PC.
- `redirect_valid`=1, `redirect_pc`=0x0A3 together with `stall`=1. Expected: next `if_id_valid`=0 with `Curr_Instr`=NOP, `pc`=0x0A0; the following edge gives `if_id.Curr_Pc`=0x0A0; `flush_count`=1.
- `halt_req`=1 alone. Expected: `halted`=1 next edge with `pc` frozen. Later redirect, stall and halt inputs have no effect. `reset` then restores `pc`=0x000 and `halted`=0.
- `halt_req`=1 and `redirect_valid`=1 in the same cycle. Expected: redirect taken, `halted` stays 0.
- Start at pc=0x1FC and advance. Expected: `if_id.Curr_Pc`=0x1FC, then `pc`=0x000 and fetch continues.
